// File: rtl/light_command_encoder_pkg.sv
// Shared code constants and exterior state type for the car light front end
// and the light controller that consumes its outputs.
package light_command_encoder_pkg;

    // Exterior indicator select codes
    localparam logic [1:0] EXT_OFF    = 2'b00;
    localparam logic [1:0] EXT_RIGHT  = 2'b01;
    localparam logic [1:0] EXT_LEFT   = 2'b10;
    localparam logic [1:0] EXT_HAZARD = 2'b11;

    // Interior main-switch codes (2'b11 is never driven)
    localparam logic [1:0] INT_ON   = 2'b00;
    localparam logic [1:0] INT_DOOR = 2'b01;
    localparam logic [1:0] INT_OFF  = 2'b10;

    // Default timing
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEFAULT_FLASH_HALF      = 8;

    // Exterior FSM state; encoding equals the exterior select code
    typedef enum logic [1:0] {
        ST_OFF    = EXT_OFF,
        ST_RIGHT  = EXT_RIGHT,
        ST_LEFT   = EXT_LEFT,
        ST_HAZARD = EXT_HAZARD
    } ext_state_e;

    // Interior encode: ON wins over DOOR, so a faulty double contact reads ON
    function automatic logic [1:0] encode_interior(input logic sw_on, input logic sw_door);
        logic [1:0] code;
        if (sw_on) begin
            code = INT_ON;
        end else if (sw_door) begin
            code = INT_DOOR;
        end else begin
            code = INT_OFF;
        end
        return code;
    endfunction

endpackage

// File: rtl/light_command_encoder_switch_debouncer.sv
// Two-flop synchroniser followed by a debounce counter. The debounced level
// only follows the synchronised input after DEBOUNCE_CYCLES consecutive
// disagreeing samples; any shorter glitch clears the counter and is lost.
module switch_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q,  sync_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          level_q, level_d;

    // Shift raw input through the synchroniser and run the stability counter
    always_comb begin
        sync_d  = {sync_q[0], raw};
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/light_command_encoder.sv
// Driver-side front end for the car light controller: debounces the cabin
// switches, latches hazard on each button press, resolves stalk/hazard
// priority and generates the flasher clock and interior switch code.
module light_command_encoder
    import light_command_encoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned FLASH_HALF      = DEFAULT_FLASH_HALF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stalk_left,
    input  logic       stalk_right,
    input  logic       hazard_btn,
    input  logic       int_sw_on,
    input  logic       int_sw_door,
    output logic [1:0] select_ext,
    output logic       flash,
    output logic [1:0] select_int,
    output logic       hazard_active
);

    localparam int unsigned FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

    logic deb_left, deb_right, deb_hazard, deb_on, deb_door;

    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
        .clk(clk), .reset(reset), .raw(stalk_left), .level(deb_left)
    );
    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .clk(clk), .reset(reset), .raw(stalk_right), .level(deb_right)
    );
    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_hazard (
        .clk(clk), .reset(reset), .raw(hazard_btn), .level(deb_hazard)
    );
    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_on (
        .clk(clk), .reset(reset), .raw(int_sw_on), .level(deb_on)
    );
    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_door (
        .clk(clk), .reset(reset), .raw(int_sw_door), .level(deb_door)
    );

    logic          haz_prev_q,      haz_prev_d;
    logic          hazard_active_q, hazard_active_d;
    ext_state_e    state_q,         state_d;
    logic [FW-1:0] flash_cnt_q,     flash_cnt_d;
    logic          flash_q,         flash_d;
    logic [1:0]    select_int_q,    select_int_d;

    // Hazard toggle, exterior priority, flasher phase and interior encode
    always_comb begin
        haz_prev_d      = deb_hazard;
        hazard_active_d = hazard_active_q ^ (deb_hazard & ~haz_prev_q);

        if (hazard_active_q) begin
            state_d = ST_HAZARD;
        end else if (deb_left && !deb_right) begin
            state_d = ST_LEFT;
        end else if (deb_right && !deb_left) begin
            state_d = ST_RIGHT;
        end else begin
            state_d = ST_OFF;
        end

        // Decided on the next state so the lamp lights on the same edge as
        // select_ext changes; any change between lit states restarts phase.
        flash_cnt_d = flash_cnt_q;
        flash_d     = flash_q;
        if (state_d == ST_OFF) begin
            flash_cnt_d = '0;
            flash_d     = 1'b0;
        end else if (state_d != state_q) begin
            flash_cnt_d = '0;
            flash_d     = 1'b1;
        end else if (flash_cnt_q == FLASH_LAST) begin
            flash_cnt_d = '0;
            flash_d     = ~flash_q;
        end else begin
            flash_cnt_d = flash_cnt_q + FW'(1);
        end

        select_int_d = encode_interior(deb_on, deb_door);
    end

    // Registered FSM and outputs, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            haz_prev_q      <= 1'b0;
            hazard_active_q <= 1'b0;
            state_q         <= ST_OFF;
            flash_cnt_q     <= '0;
            flash_q         <= 1'b0;
            select_int_q    <= INT_OFF;
        end else begin
            haz_prev_q      <= haz_prev_d;
            hazard_active_q <= hazard_active_d;
            state_q         <= state_d;
            flash_cnt_q     <= flash_cnt_d;
            flash_q         <= flash_d;
            select_int_q    <= select_int_d;
        end
    end

    assign select_ext    = state_q;
    assign flash         = flash_q;
    assign select_int    = select_int_q;
    assign hazard_active = hazard_active_q;

endmodule

// File: doc/light_command_encoder.md
Name: light_command_encoder

Overview:
- Driver-side front end for the car light controller. Produces the interior main-switch code, the exterior indicator select code and the flasher clock that the light controller consumes.
- Takes raw, bouncy cabin switches: indicator stalk left/right, hazard push button and the interior main switch.
- Debounces every input, toggles hazard on each button press, resolves stalk/hazard priority with a 4-state FSM and generates the flash square wave.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable sampled edges required before a debounced level changes (>=1)
FLASH_HALF, 8, clk cycles per flash half-period; flash period = 2*FLASH_HALF (>=2)

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  asynchronous, active-high reset
stalk_left  input  1  raw left indicator stalk contact
stalk_right  input  1  raw right indicator stalk contact
hazard_btn  input  1  raw hazard push button, momentary
int_sw_on  input  1  raw interior main switch, ON position
int_sw_door  input  1  raw interior main switch, DOOR position
select_ext  output  2  exterior code: 00 OFF, 01 RIGHT, 10 LEFT, 11 HAZARD
flash  output  1  flasher clock, gated by the controller with select_ext
select_int  output  2  interior code: 00 ON, 01 DOOR, 10 OFF (11 never driven)
hazard_active  output  1  hazard latch state, for dashboard tell-tale

Behaviour:
- Reset (async, immediate):
  - Clears all flops, including synchronisers, debounce counters, hazard latch, FSM and flash counter.
  - Output values during reset: select_ext=00, select_int=10, flash=0, hazard_active=0.
- Input path, per raw input:
  - 2-flop synchroniser, then debounce counter.
  - Counter increments while sync output != debounced level and clears when they are equal.
  - Debounced level flips on the edge where the counter reaches DEBOUNCE_CYCLES, and the counter clears.
  - Raw-to-debounced latency = 2 + DEBOUNCE_CYCLES edges.
  - Any glitch shorter than DEBOUNCE_CYCLES sampled cycles is ignored entirely.
- Hazard latch:
  - Registered rising-edge detect on debounced hazard_btn; hazard_active toggles on the following edge.
  - A button held through reset release counts as one press once debounced.
- Exterior FSM, states OFF/RIGHT/LEFT/HAZARD. Next state is evaluated every cycle:
  - hazard_active=1 -> HAZARD.
  - Otherwise left only -> LEFT.
  - Otherwise right only -> RIGHT.
  - Both or neither stalk -> OFF.
  - select_ext is the registered state code, with 1 cycle latency from the debounced/latch inputs.
- Flasher:
  - In OFF: counter=0, flash=0.
  - On any state change into a non-OFF state: counter<=0 and flash<=1 on the same edge as select_ext updates, so the indicator lights immediately.
  - Otherwise the counter counts 0..FLASH_HALF-1; at wrap, flash toggles.
  - A HAZARD->LEFT change (or any non-OFF->non-OFF change) restarts the phase.
- Interior:
  - Registered encode from debounced switches, 1 cycle latency.
  - int_sw_on has priority -> 00; else int_sw_door -> 01; else 10.
  - Both contacts closed (switch fault) resolves to 00.
- End-to-end latency, raw stable edge to select output: 3 + DEBOUNCE_CYCLES for stalks and interior; 4 + DEBOUNCE_CYCLES for hazard.

Decomposition:
- Shared package holds the code constants EXT_OFF/EXT_RIGHT/EXT_LEFT/EXT_HAZARD and INT_ON/INT_DOOR/INT_OFF, plus the FSM state type. The light controller uses the same package.
- One sub-module, switch_debouncer (synchroniser + counter, parameter DEBOUNCE_CYCLES), instantiated five times.
- Hazard latch, FSM, flasher and interior encode live in the top.

Test Plan (DEBOUNCE_CYCLES=4, FLASH_HALF=8):
- Reset, all inputs 0 -> select_ext=00, select_int=10, flash=0, hazard_active=0; values hold for 50 cycles after release.
- stalk_left bounces 1/0 every 2 cycles for 12 cycles, then holds 1 -> select_ext stays 00 during bounce.
  - select_ext=10 and flash=1 exactly 7 edges after the final rise.
  - flash then toggles every 8 cycles.
- While LEFT, hazard_btn pulsed high for 6 cycles:
  - select_ext=11 and hazard_active=1 8 edges after the press; flash restarts at 1.
  - A second press returns select_ext to 10 with phase restart.
- stalk_left=1 and stalk_right=1 held -> select_ext=00, flash=0. Release left -> 01 after 7 edges.
- int_sw_on=1 and int_sw_door=1 -> select_int=00. Drop int_sw_on -> 01 after 7 edges. Drop int_sw_door -> 10 after 7 edges.
- reset asserted mid-HAZARD flash, asynchronous to clk -> outputs return to reset values before the next edge.
  - After release with stalk_right held: hazard_active=0, select_ext=01 at edge 7.
